// File: rtl/jtbubl_romarb.sv
// jtbubl_romarb
//   Arbitrates four 8-bit CPU ROM requesters (main, sub, MCU, sound) onto a
//   single SDRAM read port. Each slot keeps a one-word (32-bit) cache so that
//   sequential byte fetches inside the same word hit without SDRAM traffic.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   downloading         ROM download in progress: arbiter idle, caches flushed
//   slotN_cs/addr       slot N request and byte address (N = 0..3)
//   slotN_ok/dout       slot N data valid for current address, and the byte
//   sdram_req/addr      read request and 16-bit-word address to the controller
//   sdram_ack           controller accepted the request
//   data_rdy/data_read  one-cycle read data strobe and 32-bit word (byte 0 in [7:0])
//
// Configuration
//   JTBUBL_ROMARB_RR_EN  defined: round-robin grant starting after the last
//                        winner; undefined: fixed priority slot0 > ... > slot3.

module jtbubl_romarb #(
  parameter int          SLOT0_AW     = 18,
  parameter int          SLOT1_AW     = 15,
  parameter int          SLOT2_AW     = 12,
  parameter int          SLOT3_AW     = 15,
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter logic [21:0] SLOT1_OFFSET = 22'h0,
  parameter logic [21:0] SLOT2_OFFSET = 22'h0,
  parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,

  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic                slot0_ok,
  output logic [7:0]          slot0_dout,

  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic                slot1_ok,
  output logic [7:0]          slot1_dout,

  input  logic                slot2_cs,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  output logic                slot2_ok,
  output logic [7:0]          slot2_dout,

  input  logic                slot3_cs,
  input  logic [SLOT3_AW-1:0] slot3_addr,
  output logic                slot3_ok,
  output logic [7:0]          slot3_dout,

  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic [21:0]         sdram_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [21:0] addr_q, addr_d;
  logic [1:0]  win_q, win_d;
  logic [21:0] wtag_q, wtag_d;

  logic [3:0]  valid_q, valid_d;
  logic [21:0] tag_q  [4];
  logic [21:0] tag_d  [4];
  logic [31:0] word_q [4];
  logic [31:0] word_d [4];

`ifdef JTBUBL_ROMARB_RR_EN
  logic [1:0]  rr_q, rr_d;
`endif

  // Slot word tags zero-extended to a common width so all slots compare alike
  logic [3:0]  cs;
  logic [21:0] tag  [4];
  logic [1:0]  lane [4];
  logic [3:0]  hit, miss;
  logic [1:0]  sel;
  logic        found;

  assign cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign tag[0]  = 22'(slot0_addr[SLOT0_AW-1:2]);
  assign tag[1]  = 22'(slot1_addr[SLOT1_AW-1:2]);
  assign tag[2]  = 22'(slot2_addr[SLOT2_AW-1:2]);
  assign tag[3]  = 22'(slot3_addr[SLOT3_AW-1:2]);
  assign lane[0] = slot0_addr[1:0];
  assign lane[1] = slot1_addr[1:0];
  assign lane[2] = slot2_addr[1:0];
  assign lane[3] = slot3_addr[1:0];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      hit[i]  = valid_q[i] && (tag_q[i] == tag[i]);
      miss[i] = cs[i] && !hit[i] && !downloading;
    end
  end

  assign slot0_ok   = slot0_cs & hit[0];
  assign slot1_ok   = slot1_cs & hit[1];
  assign slot2_ok   = slot2_cs & hit[2];
  assign slot3_ok   = slot3_cs & hit[3];
  assign slot0_dout = word_q[0][{lane[0], 3'b000} +: 8];
  assign slot1_dout = word_q[1][{lane[1], 3'b000} +: 8];
  assign slot2_dout = word_q[2][{lane[2], 3'b000} +: 8];
  assign slot3_dout = word_q[3][{lane[3], 3'b000} +: 8];

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  function automatic logic [21:0] slot_offset(input logic [1:0] idx);
    case (idx)
      2'd0:    slot_offset = SLOT0_OFFSET;
      2'd1:    slot_offset = SLOT1_OFFSET;
      2'd2:    slot_offset = SLOT2_OFFSET;
      default: slot_offset = SLOT3_OFFSET;
    endcase
  endfunction

  // Winner selection
  always_comb begin
    sel   = '0;
    found = 1'b0;
`ifdef JTBUBL_ROMARB_RR_EN
    for (int unsigned k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = rr_q + 2'(k);
      if (!found && miss[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
`else
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && miss[i]) begin
        sel   = 2'(i);
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    win_d   = win_q;
    wtag_d  = wtag_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
`ifdef JTBUBL_ROMARB_RR_EN
    rr_d    = rr_q;
`endif
    if (downloading) begin
      state_d = IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            win_d   = sel;
            wtag_d  = tag[sel];
            addr_d  = slot_offset(sel) + {tag[sel][20:0], 1'b0};
            req_d   = 1'b1;
            state_d = REQ;
`ifdef JTBUBL_ROMARB_RR_EN
            rr_d    = sel;
`endif
          end
        end
        REQ: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            // Data arriving with the ack is captured right away
            if (data_rdy) begin
              word_d[win_q]  = data_read;
              tag_d[win_q]   = wtag_q;
              valid_d[win_q] = 1'b1;
              state_d        = IDLE;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (data_rdy) begin
            word_d[win_q]  = data_read;
            tag_d[win_q]   = wtag_q;
            valid_d[win_q] = 1'b1;
            state_d        = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      win_q   <= '0;
      wtag_q  <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        word_q[i] <= '0;
      end
`ifdef JTBUBL_ROMARB_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      wtag_q  <= wtag_d;
      valid_q <= valid_d;
      for (int unsigned i = 0; i < 4; i++) begin
        tag_q[i]  <= tag_d[i];
        word_q[i] <= word_d[i];
      end
`ifdef JTBUBL_ROMARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtbubl_romarb.sv
module tb_jtbubl_romarb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        slot0_cs = 1'b0, slot1_cs = 1'b0, slot2_cs = 1'b0, slot3_cs = 1'b0;
  logic [17:0] slot0_addr = '0;
  logic [14:0] slot1_addr = '0;
  logic [11:0] slot2_addr = '0;
  logic [14:0] slot3_addr = '0;
  logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
  logic [7:0]  slot0_dout, slot1_dout, slot2_dout, slot3_dout;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] data_read = '0;
  logic [21:0] sdram_addr;

  int checks = 0;
  int failures = 0;
  logic [21:0] exp_q [$];
  int lat;

  always #5 clk = ~clk;

  jtbubl_romarb #(
    .SLOT1_OFFSET(22'h014000),
    .SLOT3_OFFSET(22'h3F0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_ok(slot0_ok), .slot0_dout(slot0_dout),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_ok(slot1_ok), .slot1_dout(slot1_dout),
    .slot2_cs(slot2_cs), .slot2_addr(slot2_addr), .slot2_ok(slot2_ok), .slot2_dout(slot2_dout),
    .slot3_cs(slot3_cs), .slot3_addr(slot3_addr), .slot3_ok(slot3_ok), .slot3_dout(slot3_dout),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .data_read(data_read), .sdram_addr(sdram_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for a request, compare its address with the scoreboard, then ack it.
  // Returns at a falling edge with the DUT waiting for data.
  task automatic req_ack(output int latency);
    logic [21:0] exp;
    latency = 0;
    while (!sdram_req && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    if (!sdram_req) begin
      check("req_timeout", 32'(sdram_req), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_req", 32'(sdram_addr), 32'h3FFFFF);
    end else begin
      exp = exp_q.pop_front();
      check("sdram_addr", 32'(sdram_addr), 32'(exp));
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    check("req_drop", 32'(sdram_req), 32'd0);
  endtask

  task automatic give_data(input logic [31:0] d);
    data_rdy  = 1'b1;
    data_read = d;
    @(negedge clk);
    data_rdy  = 1'b0;
  endtask

  initial begin
    // Reset state
    slot0_cs = 1'b1;
    slot0_addr = 18'h00005;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_ok0", 32'(slot0_ok), 32'd0);
    slot0_cs = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 1: first miss on slot 0
    slot0_cs = 1'b1;
    slot0_addr = 18'h00005;
    exp_q.push_back(22'h000002);
    req_ack(lat);
    check("t1_latency", 32'(lat), 32'd1);
    data_rdy = 1'b1;
    data_read = 32'hDDCCBBAA;
    #1 check("t1_ok_before", 32'(slot0_ok), 32'd0);
    @(negedge clk);
    data_rdy = 1'b0;
    check("t1_ok0", 32'(slot0_ok), 32'd1);
    check("t1_dout0", 32'(slot0_dout), 32'hBB);

    // 2: hits in the same word
    slot0_addr = 18'h00004; #1;
    check("t2_dout_4", 32'(slot0_dout), 32'hAA);
    check("t2_ok_4", 32'(slot0_ok), 32'd1);
    @(negedge clk);
    slot0_addr = 18'h00006; #1;
    check("t2_dout_6", 32'(slot0_dout), 32'hCC);
    @(negedge clk);
    slot0_addr = 18'h00007; #1;
    check("t2_dout_7", 32'(slot0_dout), 32'hDD);
    check("t2_ok_7", 32'(slot0_ok), 32'd1);
    @(negedge clk);
    check("t2_noreq", 32'(sdram_req), 32'd0);

    // 3: slot 1 with offset
    slot1_cs = 1'b1;
    slot1_addr = 15'h0010;
    exp_q.push_back(22'h014008);
    req_ack(lat);
    give_data(32'h44332211);
    check("t3_ok1", 32'(slot1_ok), 32'd1);
    check("t3_dout1", 32'(slot1_dout), 32'h11);
    check("t3_ok0_kept", 32'(slot0_ok), 32'd1);
    slot1_cs = 1'b0;

    // 4: simultaneous misses on slots 0 and 3
    slot0_addr = 18'h00100;
    slot3_cs = 1'b1;
    slot3_addr = 15'h0021;
`ifdef JTBUBL_ROMARB_RR_EN
    exp_q.push_back(22'h3F0010);
    exp_q.push_back(22'h000080);
`else
    exp_q.push_back(22'h000080);
    exp_q.push_back(22'h3F0010);
`endif
    req_ack(lat);
`ifdef JTBUBL_ROMARB_RR_EN
    give_data(32'h87654321);
`else
    give_data(32'h12345678);
`endif
    req_ack(lat);
`ifdef JTBUBL_ROMARB_RR_EN
    give_data(32'h12345678);
`else
    give_data(32'h87654321);
`endif
    check("t4_ok0", 32'(slot0_ok), 32'd1);
    check("t4_dout0", 32'(slot0_dout), 32'h78);
    check("t4_ok3", 32'(slot3_ok), 32'd1);
    check("t4_dout3", 32'(slot3_dout), 32'h43);

    // 5: download during WAIT
    slot2_cs = 1'b1;
    slot2_addr = 12'h004;
    exp_q.push_back(22'h000002);
    req_ack(lat);
    downloading = 1'b1;
    @(negedge clk);
    check("t5_req", 32'(sdram_req), 32'd0);
    check("t5_oks", {28'd0, slot3_ok, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
    data_rdy = 1'b1;
    data_read = 32'hFFFFFFFF;
    @(negedge clk);
    data_rdy = 1'b0;
    @(negedge clk);
    check("t5_oks_late", {28'd0, slot3_ok, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
    check("t5_req_late", 32'(sdram_req), 32'd0);
    slot0_cs = 1'b0;
    slot2_cs = 1'b0;
    slot3_cs = 1'b0;
    @(negedge clk);
    downloading = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_idle", 32'(sdram_req), 32'd0);

    // 6: address moves while the fill is outstanding
    slot0_cs = 1'b1;
    slot0_addr = 18'h00100;
    exp_q.push_back(22'h000080);
    exp_q.push_back(22'h000100);
    req_ack(lat);
    slot0_addr = 18'h00200;
    give_data(32'h55555555);
    check("t6_ok0_stale", 32'(slot0_ok), 32'd0);
    req_ack(lat);
    give_data(32'h0A0B0C0D);
    check("t6_ok0", 32'(slot0_ok), 32'd1);
    check("t6_dout0", 32'(slot0_dout), 32'h0D);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
